spwm_sequencer: RTL and testbench
=================================

SPWM_SEQUENCER -- requirements
Module: spwm_sequencer

Interface
REQ-001 SHALL have parameter Ancho, default 11, carrier counter width.
REQ-002 SHALL have parameter Div, default 4, clocks per carrier tick (Div>=1).
REQ-003 SHALL have parameter Muestras, default 256, sine samples per fundamental period; AnchoIdx, default 8, index width.
REQ-004 SHALL have parameter CiclosIni, default 1000, reset value of Ciclos_pwm.
REQ-005 clock  in  1  single clock; all state on posedge clock.
REQ-006 reset  in  1  asynchronous, active-low; acts on negedge reset.
REQ-007 start  in  1  run request, sampled every clock.
REQ-008 stop  in  1  stop request, sampled every clock.
REQ-009 Ciclos_cfg  in  Ancho  requested carrier peak value.
REQ-010 carryUp  in  1  from counter: high when count==Ciclos_pwm and e high.
REQ-011 carryDown  in  1  from counter: high when count==1 and e high.
REQ-012 e  out  1  counter enable (tick).
REQ-013 UpDown  out  1  counter direction, 1=up.
REQ-014 rst_syn  out  1  counter synchronous clear (clears count to 0).
REQ-015 Ciclos_pwm  out  Ancho  shadowed peak value driven to counter.
REQ-016 indice  out  AnchoIdx  sine sample index.
REQ-017 sync_periodo  out  1  one-clock pulse per carrier valley.
REQ-018 fin_ciclo  out  1  one-clock pulse when indice wraps.
REQ-019 activo  out  1  high while carrier runs.

Function
REQ-020 FSM states: REPOSO, ARRANQUE, SUBE, BAJA; reset state REPOSO.
REQ-021 REPOSO: start=1 and stop=0 -> ARRANQUE; stop has priority over start; stop alone ignored.
REQ-022 ARRANQUE (one clock): rst_syn=1, Ciclos_pwm<=clamp(Ciclos_cfg), indice<=0, prescaler<=0; next state SUBE.
REQ-023 clamp: Ciclos_cfg<2 SHALL load 2; otherwise load unchanged.
REQ-024 Prescaler counts 0..Div-1 in SUBE/BAJA, wraps to 0; e=1 exactly when prescaler==Div-1 in SUBE/BAJA; Div=1 gives e=1 every clock; e=0 in REPOSO/ARRANQUE.
REQ-025 UpDown combinational: SUBE -> ~carryUp; BAJA -> 0; REPOSO/ARRANQUE -> 1 (no loop: carry inputs do not depend on UpDown).
REQ-026 SUBE: carryUp=1 -> BAJA on the same edge; resulting count sequence 0,1..P,P-1..1,0,1.. with P=Ciclos_pwm; carrier period 2*P ticks.
REQ-027 BAJA: carryDown=1 (valley tick, count 1->0) -> SUBE, or REPOSO if stop pending.
REQ-028 On each valley tick: sync_periodo=1 next clock; Ciclos_pwm<=clamp(Ciclos_cfg); indice<=indice+1, wrapping Muestras-1 -> 0 with fin_ciclo=1 same clock as sync_periodo.
REQ-029 Ciclos_cfg changes mid-period SHALL NOT affect Ciclos_pwm until the next valley.
REQ-030 stop in SUBE/BAJA sets stop-pending flag; run continues to the next valley; there: state REPOSO, rst_syn=1 one clock, pending cleared, indice held.
REQ-031 start while in SUBE/BAJA/ARRANQUE SHALL be ignored.
REQ-032 activo=1 in ARRANQUE/SUBE/BAJA, 0 in REPOSO.
REQ-033 Counter module SHALL be instantiated with valor_reset=0.

Reset
REQ-034 reset low at any time, mid-period included: state REPOSO, e=0, UpDown=1, rst_syn=0, Ciclos_pwm=CiclosIni, indice=0, sync_periodo=0, fin_ciclo=0, activo=0, prescaler=0, stop-pending=0.
REQ-035 Release of reset SHALL not start the carrier; start is required.

Verification
REQ-036 Div=1, Ciclos_cfg=3, start pulse -> rst_syn one clock, then count 0,1,2,3,2,1,0,1; UpDown=0 on the tick at count 3; sync_periodo after the 1->0 tick.
REQ-037 Div=4 -> e high one clock in four; count advances only on those clocks.
REQ-038 Ciclos_cfg 3->5 during SUBE -> peak 3 in current period, peak 5 after the next valley.
REQ-039 stop during SUBE with P=3 -> carrier completes down to 0, rst_syn pulse, activo=0, e=0; count stays 0.
REQ-040 Muestras=4 -> indice 0,1,2,3,0 over four valleys; fin_ciclo on the 3->0 wrap only; Ciclos_cfg=0 -> Ciclos_pwm=2.
REQ-041 reset asserted mid-BAJA -> all outputs at REQ-034 values immediately; start after release restarts from count 0.

Source files
------------

// File: rtl/spwm_sequencer.sv
// spwm_sequencer: sequences an up/down carrier counter for sine PWM.
// On a start request it clears the external counter, loads a clamped peak
// value and then ramps the counter 0..P..0 (P = Ciclos_pwm), advancing the
// sine sample index once per carrier valley. A stop request lets the current
// carrier period finish and parks the counter at 0.
//
// Ports:
//   clock, reset (async, active-low)
//   start, stop        run / stop requests, sampled every clock
//   Ciclos_cfg         requested carrier peak, applied at the next valley
//   carryUp/carryDown  peak / valley flags from the counter (include e)
//   e, UpDown, rst_syn counter enable, direction (1=up), synchronous clear
//   Ciclos_pwm         shadowed peak value driven to the counter
//   indice             sine sample index
//   sync_periodo       one-clock pulse after each valley tick
//   fin_ciclo          one-clock pulse when indice wraps to 0
//   activo             high while the carrier runs
module spwm_sequencer #(
  parameter int Ancho     = 11,
  parameter int Div       = 4,
  parameter int Muestras  = 256,
  parameter int AnchoIdx  = 8,
  parameter int CiclosIni = 1000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic [Ancho-1:0]    Ciclos_cfg,
  input  logic                carryUp,
  input  logic                carryDown,
  output logic                e,
  output logic                UpDown,
  output logic                rst_syn,
  output logic [Ancho-1:0]    Ciclos_pwm,
  output logic [AnchoIdx-1:0] indice,
  output logic                sync_periodo,
  output logic                fin_ciclo,
  output logic                activo
);

  localparam int PW = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [PW-1:0]       PRESC_MAX = PW'(Div - 1);
  localparam logic [AnchoIdx-1:0] IDX_MAX   = AnchoIdx'(Muestras - 1);
  localparam logic [Ancho-1:0]    PICO_MIN  = Ancho'(2);

  typedef enum logic [1:0] {REPOSO, ARRANQUE, SUBE, BAJA} estado_t;

  estado_t             r_estado;
  estado_t             w_sig;
  logic [PW-1:0]       r_presc;
  logic                r_pend;
  logic                r_rst_syn;
  logic [Ancho-1:0]    r_pwm;
  logic [AnchoIdx-1:0] r_idx;
  logic                r_sync;
  logic                r_fin;
  logic                w_run;
  logic                w_valle;
  logic                w_parar;
  logic [Ancho-1:0]    w_pico;

  // Peak below 2 would make the up and down ramps degenerate.
  assign w_pico = (Ciclos_cfg < PICO_MIN) ? PICO_MIN : Ciclos_cfg;

  always_comb begin
    w_sig   = r_estado;
    w_run   = (r_estado == SUBE) || (r_estado == BAJA);
    w_valle = 1'b0;
    w_parar = 1'b0;
    e       = w_run && (r_presc == PRESC_MAX);
    UpDown  = 1'b1;
    unique case (r_estado)
      REPOSO:   if (start && !stop) w_sig = ARRANQUE;
      ARRANQUE: w_sig = SUBE;
      SUBE: begin
        // Turn around on the peak tick itself so the count goes P -> P-1.
        UpDown = ~carryUp;
        if (carryUp) w_sig = BAJA;
      end
      BAJA: begin
        UpDown = 1'b0;
        if (carryDown) begin
          w_valle = 1'b1;
          w_parar = r_pend || stop;
          w_sig   = w_parar ? REPOSO : SUBE;
        end
      end
      default: w_sig = REPOSO;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado  <= REPOSO;
      r_presc   <= '0;
      r_pend    <= 1'b0;
      r_rst_syn <= 1'b0;
      r_pwm     <= Ancho'(CiclosIni);
      r_idx     <= '0;
      r_sync    <= 1'b0;
      r_fin     <= 1'b0;
    end else begin
      r_estado  <= w_sig;
      // Clear pulse covers the ARRANQUE clock and the first clock after a stop.
      r_rst_syn <= ((r_estado == REPOSO) && (w_sig == ARRANQUE)) || w_parar;
      r_sync    <= w_valle;
      r_fin     <= w_valle && !w_parar && (r_idx == IDX_MAX);

      if (!w_run || (r_presc == PRESC_MAX)) r_presc <= '0;
      else                                  r_presc <= r_presc + 1'b1;

      if (w_valle)             r_pend <= 1'b0;
      else if (w_run && stop)  r_pend <= 1'b1;

      if ((r_estado == ARRANQUE) || w_valle) r_pwm <= w_pico;

      if (r_estado == ARRANQUE) r_idx <= '0;
      else if (w_valle && !w_parar)
        r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
    end
  end

  assign rst_syn      = r_rst_syn;
  assign Ciclos_pwm   = r_pwm;
  assign indice       = r_idx;
  assign sync_periodo = r_sync;
  assign fin_ciclo    = r_fin;
  assign activo       = (r_estado != REPOSO);

endmodule

// File: tb/tb_spwm_sequencer.sv
// Bench for spwm_sequencer: instance A (Div=1, Muestras=4) and instance B
// (Div=4) each drive a small up/down counter with clear value 0.
module tb_spwm_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_tot = 0;
  int n_bad = 0;

  // Instance A
  logic        start, stop;
  logic [10:0] cfg;
  logic        cu_a, cd_a, e_a, ud_a, rst_a, sync_a, fin_a, act_a;
  logic [10:0] pwm_a, cnt_a;
  logic [7:0]  idx_a;

  // Instance B
  logic        b_start;
  logic        cu_b, cd_b, e_b, ud_b, rst_b, sync_b, fin_b, act_b;
  logic [10:0] pwm_b, cnt_b;
  logic [7:0]  idx_b;

  spwm_sequencer #(.Ancho(11), .Div(1), .Muestras(4), .AnchoIdx(8), .CiclosIni(1000)) u_a (
    .clock(clk), .reset(rst_n), .start(start), .stop(stop), .Ciclos_cfg(cfg),
    .carryUp(cu_a), .carryDown(cd_a), .e(e_a), .UpDown(ud_a), .rst_syn(rst_a),
    .Ciclos_pwm(pwm_a), .indice(idx_a), .sync_periodo(sync_a), .fin_ciclo(fin_a),
    .activo(act_a)
  );

  spwm_sequencer #(.Ancho(11), .Div(4), .Muestras(256), .AnchoIdx(8), .CiclosIni(1000)) u_b (
    .clock(clk), .reset(rst_n), .start(b_start), .stop(1'b0), .Ciclos_cfg(11'd3),
    .carryUp(cu_b), .carryDown(cd_b), .e(e_b), .UpDown(ud_b), .rst_syn(rst_b),
    .Ciclos_pwm(pwm_b), .indice(idx_b), .sync_periodo(sync_b), .fin_ciclo(fin_b),
    .activo(act_b)
  );

  // Carrier counters (clear value 0)
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)     cnt_a <= '0;
    else if (rst_a) cnt_a <= '0;
    else if (e_a)   cnt_a <= ud_a ? cnt_a + 11'd1 : cnt_a - 11'd1;
  end
  assign cu_a = e_a && (cnt_a == pwm_a);
  assign cd_a = e_a && (cnt_a == 11'd1);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)     cnt_b <= '0;
    else if (rst_b) cnt_b <= '0;
    else if (e_b)   cnt_b <= ud_b ? cnt_b + 11'd1 : cnt_b - 11'd1;
  end
  assign cu_b = e_b && (cnt_b == pwm_b);
  assign cd_b = e_b && (cnt_b == 11'd1);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs instance A up to the next valley pulse and checks the period.
  task automatic run_period(input int exp_peak, input int exp_idx,
                            input logic exp_fin, input int exp_pwm);
    int peak = 0;
    int n = 0;
    do begin
      step();
      if (int'(cnt_a) > peak) peak = int'(cnt_a);
      n++;
    end while (!sync_a && n < 40);
    chk("valley_seen", sync_a, 1);
    chk("peak", peak, exp_peak);
    chk("indice", idx_a, exp_idx);
    chk("fin_ciclo", fin_a, exp_fin);
    chk("Ciclos_pwm", pwm_a, exp_pwm);
  endtask

  int seq_a [8] = '{0, 1, 2, 3, 2, 1, 0, 1};

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; cfg = 11'd3; b_start = 1'b0;
    step(); step();
    chk("rst_e", e_a, 0);
    chk("rst_ud", ud_a, 1);
    chk("rst_syn", rst_a, 0);
    chk("rst_pwm", pwm_a, 1000);
    chk("rst_idx", idx_a, 0);
    chk("rst_sync", sync_a, 0);
    chk("rst_fin", fin_a, 0);
    chk("rst_act", act_a, 0);

    rst_n = 1'b1;
    step(); step(); step();
    chk("no_autostart", act_a, 0);
    chk("no_autostart_e", e_a, 0);

    stop = 1'b1; step();
    chk("stop_alone", act_a, 0);
    start = 1'b1; step();
    chk("stop_prio", act_a, 0);
    start = 1'b0; stop = 1'b0;

    // Instance B: Div=4 prescaler
    b_start = 1'b1; step(); b_start = 1'b0;
    chk("b_arranque_rst", rst_b, 1);
    chk("b_arranque_e", e_b, 0);
    step();
    for (int k = 0; k < 12; k++) begin
      chk("b_e", e_b, (k % 4 == 3) ? 1 : 0);
      chk("b_cnt", cnt_b, k / 4);
      step();
    end

    // Instance A: Div=1, P=3
    start = 1'b1; step(); start = 1'b0;
    chk("arr_rst", rst_a, 1);
    chk("arr_act", act_a, 1);
    chk("arr_e", e_a, 0);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("a_cnt", cnt_a, seq_a[k]);
      if (k == 0) chk("a_pwm_load", pwm_a, 3);
      if (k == 0) chk("a_rst_drop", rst_a, 0);
      if (k == 2) chk("a_ud_up", ud_a, 1);
      if (k == 3) chk("a_ud_peak", ud_a, 0);
      if (k == 5) chk("a_sync_pre", sync_a, 0);
      if (k == 6) begin
        chk("a_sync", sync_a, 1);
        chk("a_idx1", idx_a, 1);
        chk("a_fin0", fin_a, 0);
      end
      if (k == 7) chk("a_sync_pulse", sync_a, 0);
    end

    start = 1'b1; step(); start = 1'b0;
    chk("start_ignored_rst", rst_a, 0);
    chk("start_ignored_cnt", cnt_a, 2);

    run_period(3, 2, 1'b0, 3);
    run_period(3, 3, 1'b0, 3);
    run_period(3, 0, 1'b1, 3);

    cfg = 11'd5;
    run_period(3, 1, 1'b0, 5);
    run_period(5, 2, 1'b0, 5);

    cfg = 11'd0;
    run_period(5, 3, 1'b0, 2);
    run_period(2, 0, 1'b1, 2);

    cfg = 11'd3;
    run_period(2, 1, 1'b0, 3);
    step();
    stop = 1'b1; step(); stop = 1'b0;
    run_period(3, 1, 1'b0, 3);
    chk("stop_rst", rst_a, 1);
    chk("stop_act", act_a, 0);
    chk("stop_e", e_a, 0);
    chk("stop_cnt", cnt_a, 0);
    step();
    chk("stop_rst_drop", rst_a, 0);
    repeat (5) step();
    chk("stop_cnt_hold", cnt_a, 0);
    chk("stop_e_hold", e_a, 0);

    // Reset mid-BAJA
    start = 1'b1; step(); start = 1'b0;
    run_period(3, 1, 1'b0, 3);
    repeat (4) step();
    chk("baja_ud", ud_a, 0);
    chk("baja_cnt", cnt_a, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_e", e_a, 0);
    chk("mid_rst_ud", ud_a, 1);
    chk("mid_rst_syn", rst_a, 0);
    chk("mid_rst_pwm", pwm_a, 1000);
    chk("mid_rst_idx", idx_a, 0);
    chk("mid_rst_sync", sync_a, 0);
    chk("mid_rst_fin", fin_a, 0);
    chk("mid_rst_act", act_a, 0);
    #3 rst_n = 1'b1;
    step(); step();
    chk("post_rst_idle", act_a, 0);
    start = 1'b1; step(); start = 1'b0;
    chk("restart_rst", rst_a, 1);
    step();
    chk("restart_cnt0", cnt_a, 0);
    chk("restart_pwm", pwm_a, 3);
    step();
    chk("restart_cnt1", cnt_a, 1);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

endmodule
